yarp_fetch_ctrl: RTL and testbench

Instruction fetch sequencer for the yarp core. Owns the program counter, drives a request/grant/response handshake to instruction memory, and holds one fetched instruction word stable for `yarp_decode` until the downstream stage accepts it. Accepts PC redirects from branch/jump resolution and squashes any in-flight fetch.

---
 rtl/yarp_pkg.sv | 20 ++
 rtl/yarp_fetch_ctrl.sv | 148 ++++++++++++++
 tb/tb_yarp_fetch_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/yarp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : yarp_pkg
// Description : Shared types and constants for the yarp core front end.
// Revision    : 1.0 - initial release
// ============================================================================
package yarp_pkg;

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_HOLD = 2'd2,
    FETCH_HALT = 2'd3
  } fetch_state_e;

  localparam logic [31:0] YARP_NOP      = 32'h0000_0013;
  localparam logic [31:0] YARP_RESET_PC = 32'h0000_1000;

endpackage
`default_nettype wire

// File: rtl/yarp_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : yarp_fetch_ctrl
// Description : PC owner and req/gnt/rvalid fetch sequencer with a one-entry
//               instruction hold register. Optional misaligned-redirect halt
//               is enabled by YARP_FETCH_MISALIGN_CHK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module yarp_fetch_ctrl
  import yarp_pkg::*;
#(
  parameter logic [31:0] RESET_PC = YARP_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i
`ifdef YARP_FETCH_MISALIGN_CHK_EN
  ,
  output logic        fetch_err_o
`endif
);

  localparam logic [1:0] c_st_req  = 2'(FETCH_REQ);
  localparam logic [1:0] c_st_wait = 2'(FETCH_WAIT);
  localparam logic [1:0] c_st_hold = 2'(FETCH_HOLD);
  localparam logic [1:0] c_st_halt = 2'(FETCH_HALT);

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic        r_kill;
  logic        w_kill_nxt;
  logic [31:0] r_instr;
  logic [31:0] w_instr_nxt;
  logic        r_req;
  logic [31:0] w_redir_pc;

  assign w_redir_pc = redirect_pc_i & ~32'h3;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_kill_nxt  = r_kill;
    w_instr_nxt = r_instr;
    case (r_state)
      c_st_req: begin
        if (redirect_i) begin
          w_pc_nxt = w_redir_pc;
        end
        // A grant is only meaningful while the request is actually driven.
        if (r_req && imem_gnt_i) begin
          w_state_nxt = c_st_wait;
          w_kill_nxt  = redirect_i;
        end
      end
      c_st_wait: begin
        if (redirect_i) begin
          w_pc_nxt = w_redir_pc;
          if (imem_rvalid_i) begin
            w_state_nxt = c_st_req;
            w_kill_nxt  = 1'b0;
          end else begin
            w_kill_nxt  = 1'b1;
          end
        end else if (imem_rvalid_i) begin
          if (r_kill) begin
            w_kill_nxt  = 1'b0;
            w_state_nxt = c_st_req;
          end else begin
            w_instr_nxt = imem_rdata_i;
            w_state_nxt = c_st_hold;
          end
        end
      end
      c_st_hold: begin
        if (redirect_i) begin
          w_pc_nxt    = w_redir_pc;
          w_state_nxt = c_st_req;
        end else if (instr_ready_i) begin
          w_pc_nxt    = r_pc + 32'd4;
          w_state_nxt = c_st_req;
        end
      end
      c_st_halt: begin
        w_state_nxt = c_st_halt;
      end
      default: begin
        w_state_nxt = c_st_req;
      end
    endcase
`ifdef YARP_FETCH_MISALIGN_CHK_EN
    if (redirect_i && (redirect_pc_i[1:0] != 2'b00) && (r_state != c_st_halt)) begin
      w_state_nxt = c_st_halt;
      w_kill_nxt  = 1'b0;
    end
`endif
  end

  // The request is registered from the next state so it stays low during reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_st_req;
      r_pc    <= RESET_PC;
      r_kill  <= 1'b0;
      r_instr <= YARP_NOP;
      r_req   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_kill  <= w_kill_nxt;
      r_instr <= w_instr_nxt;
      r_req   <= (w_state_nxt == c_st_req);
    end
  end

`ifdef YARP_FETCH_MISALIGN_CHK_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (redirect_i && (redirect_pc_i[1:0] != 2'b00)) begin
      r_err <= 1'b1;
    end
  end

  assign fetch_err_o = r_err;
`endif

  assign imem_req_o    = r_req;
  assign imem_addr_o   = r_pc;
  assign instr_valid_o = (r_state == c_st_hold);
  assign instr_o       = r_instr;
  assign pc_o          = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_yarp_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_yarp_fetch_ctrl
// Description : Directed vector bench for yarp_fetch_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_yarp_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
`ifdef YARP_FETCH_MISALIGN_CHK_EN
  logic        fetch_err_o;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  yarp_fetch_ctrl #(.RESET_PC(32'h0000_1000)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i)
`ifdef YARP_FETCH_MISALIGN_CHK_EN
    ,
    .fetch_err_o   (fetch_err_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs; outputs are then sampled 1ns after the edge.
  task automatic cyc(input logic rst, input logic gnt, input logic rvalid,
                     input logic [31:0] rdata, input logic ready,
                     input logic redir, input logic [31:0] rpc);
    reset         = rst;
    imem_gnt_i    = gnt;
    imem_rvalid_i = rvalid;
    imem_rdata_i  = rdata;
    instr_ready_i = ready;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_fetch(input string name, input logic req,
                              input logic [31:0] addr, input logic valid);
    chk({name, ".req"}, 32'(imem_req_o), 32'(req));
    chk({name, ".addr"}, imem_addr_o, addr);
    chk({name, ".valid"}, 32'(instr_valid_o), 32'(valid));
  endtask

  initial begin
    //           rst   gnt   rv    rdata         rdy   req   addr          val   instr         pc
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0000_1000, 1'b0, 32'h0000_0013, 32'h0000_1000};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0000_1000, 1'b0, 32'h0000_0013, 32'h0000_1000};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_1000, 1'b0, 32'h0000_0013, 32'h0000_1000};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0000_1000, 1'b0, 32'h0000_0013, 32'h0000_1000};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'h0062_8293, 1'b1, 1'b0, 32'h0000_1000, 1'b1, 32'h0062_8293, 32'h0000_1000};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_1004, 1'b0, 32'h0062_8293, 32'h0000_1004};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_1004, 1'b0, 32'h0062_8293, 32'h0000_1004};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0000_1004, 1'b0, 32'h0062_8293, 32'h0000_1004};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 32'h00A0_0513, 1'b0, 1'b0, 32'h0000_1004, 1'b1, 32'h00A0_0513, 32'h0000_1004};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0000_1004, 1'b1, 32'h00A0_0513, 32'h0000_1004};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_1008, 1'b0, 32'h00A0_0513, 32'h0000_1008};
    // rvalid outside WAIT must not disturb the hold register
    vecs[11] = '{1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0000_1008, 1'b0, 32'h00A0_0513, 32'h0000_1008};

    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 12; i++) begin
      cyc(vecs[i].rst, vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata, vecs[i].ready, 1'b0, 32'h0);
      expect_fetch($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_addr, vecs[i].exp_valid);
      chk($sformatf("vec%0d.instr", i), instr_o, vecs[i].exp_instr);
      chk($sformatf("vec%0d.pc", i), pc_o, vecs[i].exp_pc);
    end

    // Delayed grant, then downstream backpressure for 5 cycles.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      expect_fetch("gnt_wait", 1'b1, 32'h0000_1008, 1'b0);
    end
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    expect_fetch("gnt_late", 1'b0, 32'h0000_1008, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 32'h1111_1111, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      expect_fetch("hold_bp", 1'b0, 32'h0000_1008, 1'b1);
      chk("hold_bp.instr", instr_o, 32'h1111_1111);
      chk("hold_bp.pc", pc_o, 32'h0000_1008);
      cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    end
    expect_fetch("hold_bp_end", 1'b0, 32'h0000_1008, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    expect_fetch("bp_release", 1'b1, 32'h0000_100C, 1'b0);

    // Redirect during WAIT, stale response must be dropped.
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_2000);
    expect_fetch("kill_wait", 1'b0, 32'h0000_2000, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
    expect_fetch("kill_drop", 1'b1, 32'h0000_2000, 1'b0);
    chk("kill_drop.instr", instr_o, 32'h1111_1111);

    // Redirect while requesting without grant: address moves, req stays high.
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_2400);
    expect_fetch("redir_req", 1'b1, 32'h0000_2400, 1'b0);

    // Redirect in HOLD coincident with ready: no pc+4 fetch.
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 32'h2222_2222, 1'b0, 1'b0, 32'h0);
    expect_fetch("redir_hold_pre", 1'b0, 32'h0000_2400, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_3000);
    expect_fetch("redir_hold", 1'b1, 32'h0000_3000, 1'b0);

    // PC wraps from the top of the address space.
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 32'h3333_3333, 1'b0, 1'b0, 32'h0);
    chk("wrap.pc", pc_o, 32'hFFFF_FFFC);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    expect_fetch("wrap", 1'b1, 32'h0000_0000, 1'b0);

    // Reset during WAIT; the late response is ignored.
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    expect_fetch("rst_wait", 1'b0, 32'h0000_1000, 1'b0);
    chk("rst_wait.instr", instr_o, 32'h0000_0013);
    cyc(1'b0, 1'b0, 1'b1, 32'h4444_4444, 1'b0, 1'b0, 32'h0);
    expect_fetch("rst_late_rv", 1'b1, 32'h0000_1000, 1'b0);
    chk("rst_late_rv.instr", instr_o, 32'h0000_0013);

    // Misaligned redirect target.
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_2002);
`ifdef YARP_FETCH_MISALIGN_CHK_EN
    expect_fetch("misalign", 1'b0, 32'h0000_2000, 1'b0);
    chk("misalign.err", 32'(fetch_err_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 32'h5555_5555, 1'b1, 1'b0, 32'h0);
      expect_fetch("halted", 1'b0, 32'h0000_2000, 1'b0);
      chk("halted.err", 32'(fetch_err_o), 32'd1);
    end
`else
    expect_fetch("misalign", 1'b1, 32'h0000_2000, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
